// File: rtl/axi_cache_pkg.sv
// Shared types, AXI response codes and geometry helpers for the burst read cache.
package axi_cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_AR, FILL_R, RESP} state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned f_line_bytes(input int unsigned burst_len, input int unsigned m_data_w);
    return burst_len * m_data_w / 8;
  endfunction

  function automatic int unsigned f_offs_w(input int unsigned burst_len, input int unsigned m_data_w);
    return clogb2(f_line_bytes(burst_len, m_data_w));
  endfunction

  function automatic int unsigned f_word_w(input int unsigned burst_len, input int unsigned m_data_w,
                                           input int unsigned s_data_w);
    return f_offs_w(burst_len, m_data_w) - clogb2(s_data_w / 8);
  endfunction

  function automatic int unsigned f_beat_w(input int unsigned burst_len);
    return (clogb2(burst_len) > 0) ? clogb2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/axi_burst_read_cache_store.sv
// Line data array: one write port per fill beat, registered narrow-word read port.
module read_line_store import axi_cache_pkg::*; #(
  parameter int unsigned LINES     = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned S_DATA_W  = 32,
  parameter int unsigned M_DATA_W  = 256,
  parameter int unsigned LINE_W    = 2,
  parameter int unsigned BEAT_W    = 4,
  parameter int unsigned WORD_W    = 7
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [LINE_W-1:0]   i_wline,
  input  logic [BEAT_W-1:0]   i_wbeat,
  input  logic [M_DATA_W-1:0] i_wdata,
  input  logic [LINE_W-1:0]   i_rline,
  input  logic [WORD_W-1:0]   i_rword,
  output logic [S_DATA_W-1:0] o_rdata
);

  localparam int unsigned WPB = M_DATA_W / S_DATA_W;

  logic [M_DATA_W-1:0] r_mem [LINES][BURST_LEN];
  logic [S_DATA_W-1:0] r_rdata;
  logic [BEAT_W-1:0]   w_rbeat;
  logic [M_DATA_W-1:0] w_beat_data;
  int unsigned         w_sel;

  assign w_rbeat = BEAT_W'(32'(i_rword) / WPB);
  assign w_sel   = 32'(i_rword) % WPB;

  // Write-first forwarding so the beat arriving with rlast is readable on the next cycle.
  always_comb begin
    w_beat_data = r_mem[i_rline][w_rbeat];
    if (i_we && (i_wline == i_rline) && (i_wbeat == w_rbeat)) w_beat_data = i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wline][i_wbeat] <= i_wdata;
    r_rdata <= w_beat_data[w_sel*S_DATA_W +: S_DATA_W];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_burst_read_cache.sv
// Fully associative read cache: single-beat AXI slave reads served from burst-filled lines.
module axi_burst_read_cache import axi_cache_pkg::*; #(
  parameter int unsigned LINES     = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned S_DATA_W  = 32,
  parameter int unsigned M_DATA_W  = 256,
  parameter int unsigned ID_W      = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [S_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [M_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int unsigned OFFS_W = f_offs_w(BURST_LEN, M_DATA_W);
  localparam int unsigned SB_W   = clogb2(S_DATA_W / 8);
  localparam int unsigned WORD_W = f_word_w(BURST_LEN, M_DATA_W, S_DATA_W);
  localparam int unsigned BEAT_W = f_beat_w(BURST_LEN);
  localparam int unsigned LINE_W = (clogb2(LINES) > 0) ? clogb2(LINES) : 1;
  localparam int unsigned TAG_W  = ADDR_W - OFFS_W;

  state_t             r_state, w_next;
  logic [ID_W-1:0]    r_id;
  logic [TAG_W-1:0]   r_tag;
  logic [WORD_W-1:0]  r_word;
  logic [TAG_W-1:0]   r_tags [LINES];
  logic [LINES-1:0]   r_valid;
  logic [LINE_W-1:0]  r_rr, r_line, w_hit_line, w_rline;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_err, r_flush_pend;
  logic [1:0]         r_eresp;
  logic [31:0]        r_hit_cnt, r_miss_cnt;
  logic               w_any, w_hit, w_beat, w_beat_bad;

  generate
    if (SB_W > 0) begin : g_lowbits
      logic w_unused_lowbits;
      assign w_unused_lowbits = ^s_axi_araddr[SB_W-1:0];
    end
  endgenerate

  // A flush arriving during LOOKUP forces the pending request down the miss path.
  always_comb begin
    w_hit_line = '0;
    w_any      = 1'b0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (r_valid[i] && (r_tags[i] == r_tag)) begin
        w_any      = 1'b1;
        w_hit_line = LINE_W'(i);
      end
    end
    w_hit = w_any & ~flush;
  end

  assign w_beat     = (r_state == FILL_R) && m_axi_rvalid;
  assign w_beat_bad = (m_axi_rresp != OKAY);

  always_comb begin
    w_next        = r_state;
    s_axi_arready = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        s_axi_arready = rstn;
        if (s_axi_arvalid) w_next = LOOKUP;
      end
      LOOKUP:  w_next = w_hit ? RESP : FILL_AR;
      FILL_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_next = FILL_R;
      end
      FILL_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) w_next = RESP;
      end
      RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_tag        <= '0;
      r_word       <= '0;
      r_valid      <= '0;
      r_rr         <= '0;
      r_line       <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_eresp      <= OKAY;
      r_flush_pend <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (s_axi_arvalid) begin
            r_id   <= s_axi_arid;
            r_tag  <= s_axi_araddr[ADDR_W-1:OFFS_W];
            r_word <= s_axi_araddr[OFFS_W-1:SB_W];
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_line <= w_hit_line;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
          end else begin
            r_line         <= r_rr;
            r_valid[r_rr]  <= 1'b0;
            r_rr           <= (r_rr == LINE_W'(LINES - 1)) ? '0 : r_rr + 1'b1;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
          end
        end
        FILL_AR: r_beat <= '0;
        FILL_R: begin
          if (m_axi_rvalid) begin
            r_beat <= (r_beat == BEAT_W'(BURST_LEN - 1)) ? '0 : r_beat + 1'b1;
            if (w_beat_bad && !r_err) begin
              r_err   <= 1'b1;
              r_eresp <= m_axi_rresp;
            end
            if (m_axi_rlast) r_valid[r_line] <= ~(r_err | w_beat_bad);
          end
        end
        RESP: begin
          if (s_axi_rready) begin
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
            if (r_flush_pend || flush) r_valid <= '0;
          end
        end
        default: ;
      endcase
      if (flush) begin
        if ((r_state == IDLE) || (r_state == LOOKUP)) r_valid <= '0;
        else if (!((r_state == RESP) && s_axi_rready)) r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == LOOKUP) && !w_hit) r_tags[r_rr] <= r_tag;
  end

  assign w_rline = (r_state == LOOKUP) ? w_hit_line : r_line;

  read_line_store #(
    .LINES     (LINES),
    .BURST_LEN (BURST_LEN),
    .S_DATA_W  (S_DATA_W),
    .M_DATA_W  (M_DATA_W),
    .LINE_W    (LINE_W),
    .BEAT_W    (BEAT_W),
    .WORD_W    (WORD_W)
  ) u_store (
    .clk     (clk),
    .i_we    (w_beat),
    .i_wline (r_line),
    .i_wbeat (r_beat),
    .i_wdata (m_axi_rdata),
    .i_rline (w_rline),
    .i_rword (r_word),
    .o_rdata (s_axi_rdata)
  );

  assign s_axi_rid     = r_id;
  assign s_axi_rresp   = r_err ? r_eresp : OKAY;
  assign s_axi_rlast   = 1'b1;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = {r_tag, {OFFS_W{1'b0}}};
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'(clogb2(M_DATA_W / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_axi_burst_read_cache.sv
// Directed bench for axi_burst_read_cache: hits, misses, eviction, SLVERR, stalls, flush, reset.
module tb_axi_burst_read_cache;

  logic         clk, rstn, flush;
  logic [0:0]   s_axi_arid, s_axi_rid, m_axi_arid;
  logic [47:0]  s_axi_araddr, m_axi_araddr;
  logic         s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp, m_axi_arburst, m_axi_rresp;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize, m_axi_arprot;
  logic         m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [3:0]   m_axi_arcache, m_axi_arqos;
  logic [255:0] m_axi_rdata;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0]  hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] gen = 8'd0;

  axi_burst_read_cache dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Memory word at byte address a of the g-th fill reads {C0, g, a[15:0]}.
  function automatic logic [255:0] beat_data(input logic [47:0] line, input int k, input logic [7:0] g);
    logic [255:0] d;
    logic [15:0]  a;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      a = 16'(32'(line[15:0]) + k * 32 + j * 4);
      d[j*32 +: 32] = {8'hC0, g, a};
    end
    return d;
  endfunction

  task automatic read_txn(input logic [47:0] addr, input logic id, input bit miss,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input int err_beat, input int ar_stall, input int r_stall, input int flush_k);
    logic [47:0] line;
    line = {addr[47:9], 9'h000};
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    chk("arready_idle", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("arready_lookup", s_axi_arready, 1'b0);
    @(negedge clk);
    if (miss) begin
      gen = gen + 8'd1;
      chk("m_arvalid", m_axi_arvalid, 1'b1);
      chk("m_araddr", m_axi_araddr, line);
      chk("m_arlen", m_axi_arlen, 8'd15);
      for (int s = 0; s < ar_stall; s++) begin
        @(negedge clk);
        chk("m_araddr_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, line});
      end
      m_axi_arready = 1'b1;
      @(negedge clk);
      m_axi_arready = 1'b0;
      chk("m_rready", m_axi_rready, 1'b1);
      for (int k = 0; k < 16; k++) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_data(line, k, gen);
        m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (k == 15);
        flush        = (k == flush_k);
        @(negedge clk);
      end
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; flush = 1'b0;
      chk("m_rready_resp", m_axi_rready, 1'b0);
    end else begin
      chk("no_fill", m_axi_arvalid, 1'b0);
    end
    chk("s_rvalid", s_axi_rvalid, 1'b1);
    chk("s_rdata", s_axi_rdata, exp_data);
    chk("s_rresp", s_axi_rresp, exp_resp);
    chk("s_rid_rlast", {s_axi_rid, s_axi_rlast}, {id, 1'b1});
    for (int s = 0; s < r_stall; s++) begin
      @(negedge clk);
      chk("s_r_hold", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, exp_resp, exp_data});
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("s_rvalid_done", {s_axi_rvalid, s_axi_arready}, 2'b01);
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready}, 4'b0000);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
    chk("m_consts", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid}, {3'd5, 2'b01, 4'b0010, 1'b0});
    rstn = 1'b1;
    @(negedge clk);
    chk("arready_after_rst", s_axi_arready, 1'b1);

    // cold miss, then hit in same line (last beat, last word)
    read_txn(48'h1004, 1'b1, 1'b1, 32'hC0011004, 2'b00, -1, 0, 0, -1);
    chk("cnt_t1", {hit_cnt, miss_cnt}, {32'd0, 32'd1});
    read_txn(48'h11FC, 1'b0, 1'b0, 32'hC00111FC, 2'b00, -1, 0, 0, -1);
    chk("cnt_t2", {hit_cnt, miss_cnt}, {32'd1, 32'd1});

    // round-robin eviction: 0x800 evicts 0x000
    read_txn(48'h0000, 1'b0, 1'b1, 32'hC0020000, 2'b00, -1, 0, 0, -1);
    read_txn(48'h0200, 1'b0, 1'b1, 32'hC0030200, 2'b00, -1, 0, 0, -1);
    read_txn(48'h0400, 1'b0, 1'b1, 32'hC0040400, 2'b00, -1, 0, 0, -1);
    read_txn(48'h0600, 1'b0, 1'b1, 32'hC0050600, 2'b00, -1, 0, 0, -1);
    read_txn(48'h0800, 1'b0, 1'b1, 32'hC0060800, 2'b00, -1, 0, 0, -1);
    read_txn(48'h0204, 1'b1, 1'b0, 32'hC0030204, 2'b00, -1, 0, 0, -1);
    read_txn(48'h0008, 1'b0, 1'b1, 32'hC0070008, 2'b00, -1, 0, 0, -1);
    chk("cnt_t3", {hit_cnt, miss_cnt}, {32'd2, 32'd7});

    // SLVERR on beat 5 leaves the line invalid
    read_txn(48'h3020, 1'b0, 1'b1, 32'hC0083020, 2'b10, 5, 0, 0, -1);
    read_txn(48'h3020, 1'b0, 1'b1, 32'hC0093020, 2'b00, -1, 0, 0, -1);
    chk("cnt_t4", {hit_cnt, miss_cnt}, {32'd2, 32'd9});

    // AR and R backpressure, flush during fill, flush in idle
    read_txn(48'h40A4, 1'b1, 1'b1, 32'hC00A40A4, 2'b00, -1, 8, 10, -1);
    read_txn(48'h5000, 1'b0, 1'b1, 32'hC00B5000, 2'b00, -1, 0, 0, 3);
    read_txn(48'h40A4, 1'b0, 1'b1, 32'hC00C40A4, 2'b00, -1, 0, 0, -1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    read_txn(48'h40A8, 1'b0, 1'b1, 32'hC00D40A8, 2'b00, -1, 0, 0, -1);
    read_txn(48'h40AC, 1'b0, 1'b0, 32'hC00D40AC, 2'b00, -1, 0, 0, -1);
    chk("cnt_t5", {hit_cnt, miss_cnt}, {32'd3, 32'd13});

    // reset in the middle of a fill
    @(negedge clk);
    s_axi_araddr = 48'h6000; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("t6_arvalid", m_axi_arvalid, 1'b1);
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    gen = gen + 8'd1;
    for (int k = 0; k < 4; k++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = beat_data(48'h6000, k, gen);
      @(negedge clk);
    end
    rstn = 1'b0; m_axi_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_rst_outs", {s_axi_arready, s_axi_rvalid, m_axi_arvalid, m_axi_rready}, 4'b0000);
    chk("t6_rst_cnts", {hit_cnt, miss_cnt}, 64'd0);
    rstn = 1'b1;
    read_txn(48'h40AC, 1'b0, 1'b1, 32'hC00F40AC, 2'b00, -1, 0, 0, -1);
    read_txn(48'h40B0, 1'b1, 1'b0, 32'hC00F40B0, 2'b00, -1, 0, 0, -1);
    chk("cnt_t6", {hit_cnt, miss_cnt}, {32'd1, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
